// File: rtl/puf_mapping_pkg.sv
// Shared constants and FSM state type for the PUF mapping block.
package puf_mapping_pkg;

  localparam int unsigned CHALLENGE_WIDTH_DEF  = 64;
  localparam int unsigned PDL_CONFIG_WIDTH_DEF = 128;
  localparam int unsigned RESPONSE_WIDTH_DEF   = 6;
  localparam int unsigned STAGE_WEIGHT_BITS    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EVAL    = 2'd2
  } state_t;

endpackage

// File: rtl/arbiter_slice.sv
// Linear arbiter-delay model: signed sum of per-stage weights, sign picks the response bit.
module arbiter_slice
  import puf_mapping_pkg::*;
#(
  parameter int unsigned CHALLENGE_WIDTH  = CHALLENGE_WIDTH_DEF,
  parameter int unsigned PDL_CONFIG_WIDTH = PDL_CONFIG_WIDTH_DEF
) (
  input  logic [CHALLENGE_WIDTH-1:0]  challenge,
  input  logic [PDL_CONFIG_WIDTH-1:0] pdl_config,
  output logic                        response_c
);

  // Wide enough for +/- 4*CHALLENGE_WIDTH plus sign with margin.
  localparam int unsigned ACC_W = $clog2(4 * CHALLENGE_WIDTH) + 2;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] weight;
  logic             parity;

  // Walk stages from MSB down so the running parity equals XOR of challenge[CW-1:k].
  always_comb begin
    acc    = '0;
    weight = '0;
    parity = 1'b0;
    for (int k = CHALLENGE_WIDTH - 1; k >= 0; k--) begin
      parity = parity ^ challenge[k];
      weight = ACC_W'(pdl_config[STAGE_WEIGHT_BITS*k +: STAGE_WEIGHT_BITS]) + ACC_W'(1);
      acc    = parity ? (acc + weight) : (acc - weight);
    end
    // Strictly positive: sign bit clear and not zero; ties resolve to 0.
    response_c = !acc[ACC_W-1] && (acc != '0);
  end

endmodule

// File: rtl/puf_mapping.sv
// Distributes one config and one rotated challenge per arbiter slice, evaluates on trigger.
module puf_mapping
  import puf_mapping_pkg::*;
#(
  parameter int unsigned CHALLENGE_WIDTH  = CHALLENGE_WIDTH_DEF,
  parameter int unsigned PDL_CONFIG_WIDTH = PDL_CONFIG_WIDTH_DEF,
  parameter int unsigned RESPONSE_WIDTH   = RESPONSE_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trigger,
  input  logic [PDL_CONFIG_WIDTH-1:0] pdl_config,
  input  logic [CHALLENGE_WIDTH-1:0]  challenge,
  output logic                        done,
  output logic [RESPONSE_WIDTH-1:0]   raw_response,
  output logic                        xor_response
);

  if (PDL_CONFIG_WIDTH != STAGE_WEIGHT_BITS * CHALLENGE_WIDTH) begin : g_bad_cfg_width
    $error("puf_mapping: PDL_CONFIG_WIDTH must equal 2*CHALLENGE_WIDTH");
  end
  if (RESPONSE_WIDTH < 1 || RESPONSE_WIDTH > CHALLENGE_WIDTH) begin : g_bad_resp_width
    $error("puf_mapping: RESPONSE_WIDTH must be in 1..CHALLENGE_WIDTH");
  end

  state_t state;
  state_t state_next;

  logic latch_en_c;
  logic compute_en_c;
  logic publish_c;

  logic [PDL_CONFIG_WIDTH-1:0] cfg_q;
  logic [CHALLENGE_WIDTH-1:0]  chal_q;
  logic [RESPONSE_WIDTH-1:0]   result_q;
  logic [RESPONSE_WIDTH-1:0]   slice_resp_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Trigger is only looked at in IDLE, so re-assertions mid-evaluation are dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = CAPTURE;
      CAPTURE: state_next = EVAL;
      EVAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    latch_en_c   = 1'b0;
    compute_en_c = 1'b0;
    publish_c    = 1'b0;
    case (state)
      IDLE:    latch_en_c   = trigger;
      CAPTURE: compute_en_c = 1'b1;
      EVAL:    publish_c    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q        <= '0;
      chal_q       <= '0;
      result_q     <= '0;
      done         <= 1'b0;
      raw_response <= '0;
      xor_response <= 1'b0;
    end else begin
      if (latch_en_c) begin
        cfg_q  <= pdl_config;
        chal_q <= challenge;
      end
      if (compute_en_c) begin
        result_q <= slice_resp_c;
      end
      done <= publish_c;
      if (publish_c) begin
        raw_response <= result_q;
        xor_response <= ^result_q;
      end
    end
  end

  // Slice i sees the latched challenge rotated left by i bits.
  for (genvar i = 0; i < RESPONSE_WIDTH; i++) begin : g_slice
    logic [CHALLENGE_WIDTH-1:0] rot_chal;

    always_comb begin
      rot_chal = '0;
      for (int j = 0; j < CHALLENGE_WIDTH; j++) begin
        rot_chal[j] = chal_q[(j + CHALLENGE_WIDTH - i) % CHALLENGE_WIDTH];
      end
    end

    arbiter_slice #(
      .CHALLENGE_WIDTH (CHALLENGE_WIDTH),
      .PDL_CONFIG_WIDTH(PDL_CONFIG_WIDTH)
    ) u_slice (
      .challenge (rot_chal),
      .pdl_config(cfg_q),
      .response_c(slice_resp_c[i])
    );
  end

endmodule

// File: tb/tb_puf_mapping.sv
// Self-checking bench for puf_mapping: directed cases plus randomized evaluations against a reference model.
module tb_puf_mapping;

  localparam int unsigned CW = 64;
  localparam int unsigned PW = 128;
  localparam int unsigned RW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          trigger;
  logic [PW-1:0] pdl_config;
  logic [CW-1:0] challenge;
  logic          done;
  logic [RW-1:0] raw_response;
  logic          xor_response;

  int n_checks = 0;
  int n_pass   = 0;

  puf_mapping #(
    .CHALLENGE_WIDTH (CW),
    .PDL_CONFIG_WIDTH(PW),
    .RESPONSE_WIDTH  (RW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .pdl_config  (pdl_config),
    .challenge   (challenge),
    .done        (done),
    .raw_response(raw_response),
    .xor_response(xor_response)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: rotate, count ones above each stage for the feature, integer delay sum.
  function automatic logic [RW-1:0] ref_resp(input logic [PW-1:0] cfg, input logic [CW-1:0] ch);
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    int d, ones, w;
    r = '0;
    for (int i = 0; i < RW; i++) begin
      c = (i == 0) ? ch : ((ch << i) | (ch >> (CW - i)));
      d = 0;
      for (int k = 0; k < CW; k++) begin
        ones = 0;
        for (int j = k; j < CW; j++) ones += int'(c[j]);
        w = int'(cfg[2*k +: 2]) + 1;
        d += (ones % 2 == 1) ? w : -w;
      end
      r[i] = (d > 0);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger one evaluation, scramble inputs after capture, check timing and result.
  task automatic eval_check(input string tag, input logic [PW-1:0] cfg,
                            input logic [CW-1:0] ch, input logic [RW-1:0] exp_raw);
    pdl_config = cfg;
    challenge  = ch;
    trigger    = 1'b1;
    tick();
    trigger    = 1'b0;
    pdl_config = ~cfg;
    challenge  = ~ch;
    check({tag, ".done_t0"}, 64'(done), 64'd0);
    tick();
    check({tag, ".done_t1"}, 64'(done), 64'd0);
    tick();
    check({tag, ".done_t2"}, 64'(done), 64'd1);
    check({tag, ".raw"}, 64'(raw_response), 64'(exp_raw));
    check({tag, ".xor"}, 64'(xor_response), 64'(^exp_raw));
    tick();
    check({tag, ".done_t3"}, 64'(done), 64'd0);
    check({tag, ".raw_hold"}, 64'(raw_response), 64'(exp_raw));
  endtask

  initial begin
    logic [PW-1:0] cfg_a, cfg_b, cfg_cc;
    logic [CW-1:0] ch_a, ch_b;
    logic [RW-1:0] exp_a, exp_b;

    cfg_cc     = {32{4'hC}};
    reset      = 1'b1;
    trigger    = 1'b0;
    pdl_config = '0;
    challenge  = '0;
    tick();
    tick();
    check("reset.done", 64'(done), 64'd0);
    check("reset.raw", 64'(raw_response), 64'd0);
    check("reset.xor", 64'(xor_response), 64'd0);
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("idle.no_done", 64'(done), 64'd0);
    end

    eval_check("cfg0_ch0", '0, '0, 6'b000000);
    eval_check("cfg0_msb", '0, 64'h8000_0000_0000_0000, 6'b000001);
    eval_check("cfg0_ones", '0, '1, 6'b000000);
    eval_check("cfgcc_ones", cfg_cc, '1, 6'b111111);

    for (int n = 0; n < 12; n++) begin
      cfg_a = {$urandom, $urandom, $urandom, $urandom};
      ch_a  = {$urandom, $urandom};
      if (n % 3 == 0) cfg_a = {32{4'hC}} ^ (cfg_a & {4{32'h0101_0101}});
      eval_check($sformatf("rand%0d", n), cfg_a, ch_a, ref_resp(cfg_a, ch_a));
    end

    // Trigger held high: repeats at T+1, T+2 ignored, T+3 accepted with new inputs.
    cfg_a = {$urandom, $urandom, $urandom, $urandom};
    ch_a  = {$urandom, $urandom};
    cfg_b = ~cfg_a;
    ch_b  = {ch_a[31:0], ch_a[63:32]} ^ 64'h5A5A_0000_FFFF_1234;
    exp_a = ref_resp(cfg_a, ch_a);
    exp_b = ref_resp(cfg_b, ch_b);
    pdl_config = cfg_a;
    challenge  = ch_a;
    trigger    = 1'b1;
    tick();
    pdl_config = cfg_b;
    challenge  = ch_b;
    check("hold.done_t0", 64'(done), 64'd0);
    tick();
    check("hold.done_t1", 64'(done), 64'd0);
    tick();
    check("hold.done_t2", 64'(done), 64'd1);
    check("hold.raw_a", 64'(raw_response), 64'(exp_a));
    check("hold.xor_a", 64'(xor_response), 64'(^exp_a));
    tick();
    trigger = 1'b0;
    check("hold.done_t3", 64'(done), 64'd0);
    tick();
    check("hold.done_t4", 64'(done), 64'd0);
    tick();
    check("hold.done_t5", 64'(done), 64'd1);
    check("hold.raw_b", 64'(raw_response), 64'(exp_b));
    check("hold.xor_b", 64'(xor_response), 64'(^exp_b));
    tick();

    // Reset during CAPTURE aborts and clears outputs.
    eval_check("pre_abort", '0, 64'h8000_0000_0000_0000, 6'b000001);
    pdl_config = cfg_cc;
    challenge  = '1;
    trigger    = 1'b1;
    tick();
    trigger = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.done", 64'(done), 64'd0);
    check("abort.raw", 64'(raw_response), 64'd0);
    check("abort.xor", 64'(xor_response), 64'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      check("abort.no_done", 64'(done), 64'd0);
    end
    eval_check("post_abort", cfg_cc, '1, 6'b111111);

    // Reset wins over a simultaneous trigger.
    reset   = 1'b1;
    trigger = 1'b1;
    tick();
    reset   = 1'b0;
    trigger = 1'b0;
    check("rst_dom.raw", 64'(raw_response), 64'd0);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("rst_dom.no_done", 64'(done), 64'd0);
    end
    eval_check("final", '0, 64'h8000_0000_0000_0000, 6'b000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
